vec_lsu: RTL and testbench

- Vector load/store unit between the execute stage and the 16-lane x 16-bit data memory of the SIMD FIR core.
- Accepts one memory request at a time over a valid/ready handshake and drives the memory's single port (WE, A, WD; combinational RD).
- Normalises lane ordering and returns load data to writeback.
- Implements scalar stores by read-modify-write, because the memory always writes 16 consecutive words.

---
 rtl/vec_pkg.sv | 37 +++
 rtl/vec_lsu_lane_reverse.sv | 17 +
 rtl/vec_lsu.sv | 145 ++++++++++++++
 tb/tb_vec_lsu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared constants, opcode and state encodings for the vector load/store unit.
// Purely declarative; no logic, no latency, no flow control.
package vec_pkg;

  localparam int LANES     = 16;
  localparam int DW        = 16;
  localparam int AW        = 16;
  localparam int DEPTH     = 1024;
  localparam int BW        = LANES * DW;
  localparam int LAST_BASE = DEPTH - LANES;

  typedef enum logic [1:0] {
    OP_VLD = 2'b00,
    OP_VST = 2'b01,
    OP_SLD = 2'b10,
    OP_SST = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Request fields kept past the accept edge; the address lives in mem_a_q.
  typedef struct packed {
    op_e           op;
    logic [DW-1:0] wdata0;
  } req_t;

  // A base is legal only if the whole LANES-word block fits below DEPTH.
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return addr <= AW'(LAST_BASE);
  endfunction

endpackage

// File: rtl/vec_lsu_lane_reverse.sv
// Swaps word order across LANES lanes: out lane i takes in lane LANES-1-i.
// Combinational, zero latency, no flow control.
module lane_reverse
  import vec_pkg::*;
(
  input  logic [BW-1:0] in_dat,
  output logic [BW-1:0] out_dat
);

  always_comb begin
    out_dat = '0;
    for (int i = 0; i < LANES; i++) begin
      out_dat[i*DW +: DW] = in_dat[(LANES-1-i)*DW +: DW];
    end
  end

endmodule

// File: rtl/vec_lsu.sv
// Vector LSU: one request in flight, drives a 16-word single-port memory; SST is read-modify-write.
// Accept->resp_valid: VLD/SLD/VST 2, SST 3, range error 1; req_ready only in IDLE, resp held until resp_ready.
module vec_lsu
  import vec_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [BW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [BW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [BW-1:0] mem_wd,
  input  logic [BW-1:0] mem_rd
);

  lsu_state_e    state_q, state_d;
  req_t          req_q, req_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [BW-1:0] resp_rdata_q, resp_rdata_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [BW-1:0] mem_wd_q, mem_wd_d;
  logic [BW-1:0] rd_norm;
  logic          accept;

  // Memory returns the word at A in the top lane; normalise so lane i = word A+i.
  lane_reverse u_rev (
    .in_dat  (mem_rd),
    .out_dat (rd_norm)
  );

  assign accept = req_valid & req_ready_q;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_we_d     = 1'b0;
    mem_a_d      = mem_a_q;
    mem_wd_d     = mem_wd_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d.op     = op_e'(req_op);
          req_d.wdata0 = req_wdata[DW-1:0];
          mem_a_d      = req_addr;
          req_ready_d  = 1'b0;
          if (!addr_in_range(req_addr)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (op_e'(req_op) == OP_VST) begin
            state_d  = ST_WR;
            mem_we_d = 1'b1;
            mem_wd_d = req_wdata;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (req_q.op == OP_SST) begin
          // Write the block back with only word 0 replaced.
          state_d  = ST_WR;
          mem_we_d = 1'b1;
          mem_wd_d = {rd_norm[BW-1:DW], req_q.wdata0};
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = (req_q.op == OP_SLD) ? {{(BW-DW){1'b0}}, rd_norm[DW-1:0]} : rd_norm;
        end
      end

      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= '{op: OP_VLD, wdata0: '0};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_wd_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_a_q      <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_vec_lsu.sv
// Directed bench for vec_lsu with a behavioural 1024-word, 16-lane single-port memory.
module tb_vec_lsu;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [15:0]  req_addr;
  logic [255:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [255:0] resp_rdata;
  logic         resp_err;
  logic         mem_we;
  logic [15:0]  mem_a;
  logic [255:0] mem_wd;
  logic [255:0] mem_rd;

  logic [15:0] mem [0:1023] = '{default: 16'h0000};
  int we_edges = 0;
  int bad_we   = 0;
  int accepts  = 0;
  int n_cmp    = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vec_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Memory model: word at A on [255:240] for reads, on [15:0] for writes.
  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 16; i++) begin
      if (int'(mem_a) + i < 1024) mem_rd[255-16*i -: 16] = mem[int'(mem_a) + i];
    end
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) accepts <= accepts + 1;
    if (mem_we) begin
      we_edges <= we_edges + 1;
      if (mem_a > 16'd1008) bad_we <= bad_we + 1;
      for (int i = 0; i < 16; i++) begin
        if (int'(mem_a) + i < 1024) mem[int'(mem_a) + i] <= mem_wd[16*i +: 16];
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [255:0] wdata,
                       output int lat, output logic [255:0] rdata, output logic err, output int wes);
    int we0;
    int n;
    we0 = we_edges;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0; req_wdata = '0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    wes = we_edges - we0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
    n_cmp++; if (resp_rdata !== 256'h0) begin n_fail++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_a !== 16'h0) begin n_fail++; $display("FAIL rst_mem_a got %h want 0", mem_a); end
    n_cmp++; if (mem_wd !== 256'h0) begin n_fail++; $display("FAIL rst_mem_wd got %h want 0", mem_wd); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vst_vld;
    logic [255:0] pat, rd;
    logic err;
    int lat, wes;
    for (int i = 0; i < 16; i++) pat[16*i +: 16] = 16'h1000 + 16'(i);
    issue(2'b01, 16'h0020, pat, lat, rd, err, wes);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL vst_latency got %0d want 2", lat); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL vst_err got %b want 0", err); end
    n_cmp++; if (wes != 1) begin n_fail++; $display("FAIL vst_we_cycles got %0d want 1", wes); end
    n_cmp++; if (rd !== 256'h0) begin n_fail++; $display("FAIL vst_rdata got %h want 0", rd); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (mem[32+i] !== 16'h1000 + 16'(i)) begin n_fail++; $display("FAIL vst_mem_word%0d got %h want %h", i, mem[32+i], 16'h1000 + 16'(i)); end
    end
    issue(2'b00, 16'h0020, '0, lat, rd, err, wes);
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL vld_latency got %0d want 2", lat); end
    n_cmp++; if (rd !== pat) begin n_fail++; $display("FAIL vld_rdata got %h want %h", rd, pat); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL vld_err got %b want 0", err); end
    n_cmp++; if (wes != 0) begin n_fail++; $display("FAIL vld_we_cycles got %0d want 0", wes); end
  endtask

  task automatic test_sst;
    logic [255:0] pat, exp, rd;
    logic err;
    int lat, wes;
    for (int i = 0; i < 16; i++) pat[16*i +: 16] = 16'hAA00 + 16'(i);
    issue(2'b01, 16'h0040, pat, lat, rd, err, wes);
    exp = pat;
    exp[15:0] = 16'hBEEF;
    issue(2'b11, 16'h0040, {240'h0, 16'hBEEF}, lat, rd, err, wes);
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL sst_latency got %0d want 3", lat); end
    n_cmp++; if (wes != 1) begin n_fail++; $display("FAIL sst_we_cycles got %0d want 1", wes); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL sst_err got %b want 0", err); end
    issue(2'b00, 16'h0040, '0, lat, rd, err, wes);
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL sst_readback got %h want %h", rd, exp); end
  endtask

  task automatic test_sld;
    logic [255:0] rd;
    logic err;
    int lat, wes;
    issue(2'b10, 16'h0041, {256{1'b1}}, lat, rd, err, wes);
    n_cmp++; if (rd !== {240'h0, 16'hAA01}) begin n_fail++; $display("FAIL sld_rdata got %h want %h", rd, {240'h0, 16'hAA01}); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL sld_latency got %0d want 2", lat); end
    n_cmp++; if (wes != 0) begin n_fail++; $display("FAIL sld_we_cycles got %0d want 0", wes); end
  endtask

  task automatic test_bounds;
    logic [255:0] rd;
    logic err;
    int lat, wes;
    issue(2'b00, 16'h03F0, '0, lat, rd, err, wes);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL bound_last_err got %b want 0", err); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL bound_last_latency got %0d want 2", lat); end
    issue(2'b01, 16'h03F1, {256{1'b1}}, lat, rd, err, wes);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL bound_vst_err got %b want 1", err); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL bound_vst_latency got %0d want 1", lat); end
    n_cmp++; if (wes != 0) begin n_fail++; $display("FAIL bound_vst_we got %0d want 0", wes); end
    n_cmp++; if (rd !== 256'h0) begin n_fail++; $display("FAIL bound_vst_rdata got %h want 0", rd); end
    issue(2'b00, 16'hFFFF, '0, lat, rd, err, wes);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL bound_ffff_err got %b want 1", err); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL bound_ffff_latency got %0d want 1", lat); end
    n_cmp++; if (rd !== 256'h0) begin n_fail++; $display("FAIL bound_ffff_rdata got %h want 0", rd); end
  endtask

  task automatic test_backpressure;
    logic [255:0] exp0, exp1, held;
    int acc0, lat;
    for (int i = 0; i < 16; i++) begin
      exp0[16*i +: 16] = 16'hAA00 + 16'(i);
      exp1[16*i +: 16] = 16'h1000 + 16'(i);
    end
    exp0[15:0] = 16'hBEEF;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h0040; req_wdata = '0;
    @(negedge clk);
    acc0 = accepts;
    req_addr = 16'h0020;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    held = resp_rdata;
    n_cmp++; if (held !== exp0) begin n_fail++; $display("FAIL bp_first_rdata got %h want %h", held, exp0); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc%0d got %b want 1", k, resp_valid); end
      n_cmp++; if (resp_rdata !== held) begin n_fail++; $display("FAIL bp_hold_rdata cyc%0d got %h want %h", k, resp_rdata, held); end
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready cyc%0d got %b want 0", k, req_ready); end
      n_cmp++; if (accepts != acc0) begin n_fail++; $display("FAIL bp_no_accept cyc%0d got %0d want %0d", k, accepts, acc0); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop got %b want 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got %b want 1", req_ready); end
    n_cmp++; if (accepts != acc0) begin n_fail++; $display("FAIL bp_same_cycle_accept got %0d want %0d", accepts, acc0); end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (accepts != acc0 + 1) begin n_fail++; $display("FAIL bp_pending_accept got %0d want %0d", accepts, acc0 + 1); end
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL bp_second_latency got %0d want 2", lat); end
    n_cmp++; if (resp_rdata !== exp1) begin n_fail++; $display("FAIL bp_second_rdata got %h want %h", resp_rdata, exp1); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_sst;
    int we0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_addr = 16'h0020; req_wdata = {240'h0, 16'hDEAD};
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL mid_sst_we_before got %b want 1", mem_we); end
    we0 = we_edges;
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_sst_we_drop got %b want 0", mem_we); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_sst_req_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_sst_resp_valid got %b want 0", resp_valid); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (we_edges != we0) begin n_fail++; $display("FAIL mid_sst_no_write got %0d want %0d", we_edges, we0); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_sst_no_resp got %b want 0", resp_valid); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (mem[32+i] !== 16'h1000 + 16'(i)) begin n_fail++; $display("FAIL mid_sst_mem_word%0d got %h want %h", i, mem[32+i], 16'h1000 + 16'(i)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0; req_wdata = '0;
    resp_ready = 1'b0;
    test_reset();
    test_vst_vld();
    test_sst();
    test_sld();
    test_bounds();
    test_backpressure();
    test_reset_mid_sst();
    n_cmp++; if (bad_we != 0) begin n_fail++; $display("FAIL out_of_range_write got %0d want 0", bad_we); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
